// File: rtl/usb_boot_pkg.sv
// Shared state encoding, default timing parameters and the parameter range helper
// used by the bootloader exit sequencer.
package usb_boot_pkg;

  typedef enum logic [2:0] {
    ST_ARMED   = 3'd0,
    ST_SESSION = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_DETACH  = 3'd3,
    ST_PROGRAM = 3'd4
  } boot_state_e;

  localparam int unsigned IDLE_TIMEOUT_DEF  = 32'd240000000;
  localparam int unsigned QUIET_CYCLES_DEF  = 32'd16;
  localparam int unsigned DETACH_CYCLES_DEF = 32'd480000;
  localparam int unsigned CNT_W_DEF         = 32'd32;

  // True when value v is representable in an unsigned counter of w bits.
  function automatic logic param_fits(input longint unsigned v, input int unsigned w);
    return (v < (64'd1 << w));
  endfunction

endpackage

// File: rtl/usb_boot_sequencer_seq_timer.sv
// Saturating up-counter shared by the sequencer's ARMED, DRAIN and DETACH phases.
// done_o flags that the count currently equals the terminal value tc_i.
module seq_timer
  import usb_boot_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturation keeps the count from wrapping if a phase is left running indefinitely.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/usb_boot_sequencer.sv
// Bootloader exit sequencer: idle auto-boot, SPI flash drain and lock, USB detach,
// then a held-low user_programn until reset.
module usb_boot_sequencer
  import usb_boot_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT  = IDLE_TIMEOUT_DEF,
  parameter int unsigned QUIET_CYCLES  = QUIET_CYCLES_DEF,
  parameter int unsigned DETACH_CYCLES = DETACH_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       boot_req,
  input  logic       usb_active,
  input  logic       spi_cs_n_in,
  output logic       spi_cs_n_out,
  output logic       spi_locked,
  output logic       usb_pu_dp,
  output logic       user_programn,
  output logic [2:0] state_o
);

  if (!param_fits(64'(IDLE_TIMEOUT), CNT_W) || !param_fits(64'(QUIET_CYCLES), CNT_W) ||
      !param_fits(64'(DETACH_CYCLES), CNT_W)) begin : g_cnt_w_check
    $error("usb_boot_sequencer: a timing parameter does not fit in CNT_W bits");
  end

  if ((QUIET_CYCLES == 32'd0) || (DETACH_CYCLES == 32'd0)) begin : g_nonzero_check
    $error("usb_boot_sequencer: QUIET_CYCLES and DETACH_CYCLES must be non-zero");
  end

  localparam logic [CNT_W-1:0] TC_IDLE   = CNT_W'(IDLE_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] TC_QUIET  = CNT_W'(QUIET_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TC_DETACH = CNT_W'(DETACH_CYCLES - 32'd1);
  localparam logic             TIMEOUT_EN = (IDLE_TIMEOUT != 32'd0);

  boot_state_e      state_q;
  boot_state_e      state_d;
  logic             t_clr_s;
  logic             t_en_s;
  logic             t_done_s;
  logic [CNT_W-1:0] t_tc_s;
  logic             locked_q;
  logic             pu_q;
  logic             programn_q;

  seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk_48mhz),
    .rst_i      (reset),
    .clr_i      (t_clr_s),
    .en_i       (t_en_s),
    .load_i     (1'b0),
    .load_val_i ({CNT_W{1'b0}}),
    .tc_i       (t_tc_s),
    .done_o     (t_done_s)
  );

  // Next state and timer control; every phase change restarts the shared counter.
  always_comb begin
    state_d = state_q;
    t_clr_s = 1'b0;
    t_en_s  = 1'b0;
    t_tc_s  = TC_IDLE;
    case (state_q)
      ST_ARMED: begin
        t_tc_s = TC_IDLE;
        if (boot_req) begin
          state_d = ST_DRAIN;
          t_clr_s = 1'b1;
        end else if (usb_active) begin
          state_d = ST_SESSION;
          t_clr_s = 1'b1;
        end else if (TIMEOUT_EN && t_done_s) begin
          state_d = ST_DRAIN;
          t_clr_s = 1'b1;
        end else begin
          t_en_s = 1'b1;
        end
      end
      ST_SESSION: begin
        t_clr_s = 1'b1;
        if (boot_req) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_SESSION;
        end
      end
      ST_DRAIN: begin
        t_tc_s = TC_QUIET;
        // Any low chip-select means a transaction is in flight: restart the quiet window.
        if (!spi_cs_n_in) begin
          t_clr_s = 1'b1;
        end else if (t_done_s) begin
          state_d = ST_DETACH;
          t_clr_s = 1'b1;
        end else begin
          t_en_s = 1'b1;
        end
      end
      ST_DETACH: begin
        t_tc_s = TC_DETACH;
        if (t_done_s) begin
          state_d = ST_PROGRAM;
          t_clr_s = 1'b1;
        end else begin
          t_en_s = 1'b1;
        end
      end
      ST_PROGRAM: begin
        state_d = ST_PROGRAM;
        t_clr_s = 1'b1;
      end
      default: begin
        state_d = ST_ARMED;
        t_clr_s = 1'b1;
      end
    endcase
  end

  // State register plus outputs registered from the current state (one cycle behind it).
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q    <= ST_ARMED;
      locked_q   <= 1'b0;
      pu_q       <= 1'b1;
      programn_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      locked_q   <= (state_q == ST_DETACH) || (state_q == ST_PROGRAM);
      pu_q       <= !((state_q == ST_DETACH) || (state_q == ST_PROGRAM));
      programn_q <= (state_q != ST_PROGRAM);
    end
  end

  assign spi_cs_n_out  = spi_cs_n_in | locked_q;
  assign spi_locked    = locked_q;
  assign usb_pu_dp     = pu_q;
  assign user_programn = programn_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_usb_boot_sequencer.sv
// Self-checking bench for usb_boot_sequencer: directed scenarios plus randomized
// traffic, every cycle compared against a behavioural model of the boot sequence.
module tb_usb_boot_sequencer;

  localparam int IT = 100;
  localparam int QC = 4;
  localparam int DC = 20;

  localparam int M_ARMED = 0, M_SESSION = 1, M_DRAIN = 2, M_DETACH = 3, M_PROGRAM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       boot_req = 1'b0;
  logic       usb_active = 1'b0;
  logic       spi_cs_n_in = 1'b1;
  logic       spi_cs_n_out;
  logic       spi_locked;
  logic       usb_pu_dp;
  logic       user_programn;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  usb_boot_sequencer #(
    .IDLE_TIMEOUT  (IT),
    .QUIET_CYCLES  (QC),
    .DETACH_CYCLES (DC),
    .CNT_W         (32)
  ) dut (
    .clk_48mhz     (clk),
    .reset         (reset),
    .boot_req      (boot_req),
    .usb_active    (usb_active),
    .spi_cs_n_in   (spi_cs_n_in),
    .spi_cs_n_out  (spi_cs_n_out),
    .spi_locked    (spi_locked),
    .usb_pu_dp     (usb_pu_dp),
    .user_programn (user_programn),
    .state_o       (state_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: phase, elapsed cycles in phase, and the pin levels lagging phase by one cycle.
  int   m_phase = M_ARMED;
  int   m_elapsed = 0;
  logic m_locked = 1'b0;
  logic m_pu = 1'b1;
  logic m_progn = 1'b1;

  task automatic model_edge();
    if (reset) begin
      m_phase = M_ARMED; m_elapsed = 0;
      m_locked = 1'b0; m_pu = 1'b1; m_progn = 1'b1;
    end else begin
      m_locked = (m_phase >= M_DETACH);
      m_pu     = (m_phase < M_DETACH);
      m_progn  = (m_phase != M_PROGRAM);
      case (m_phase)
        M_ARMED:
          if (boot_req) begin m_phase = M_DRAIN; m_elapsed = 0; end
          else if (usb_active) begin m_phase = M_SESSION; m_elapsed = 0; end
          else if (IT != 0 && m_elapsed + 1 == IT) begin m_phase = M_DRAIN; m_elapsed = 0; end
          else m_elapsed++;
        M_SESSION: begin
          m_elapsed = 0;
          if (boot_req) m_phase = M_DRAIN;
        end
        M_DRAIN:
          if (!spi_cs_n_in) m_elapsed = 0;
          else if (m_elapsed + 1 == QC) begin m_phase = M_DETACH; m_elapsed = 0; end
          else m_elapsed++;
        M_DETACH:
          if (m_elapsed + 1 == DC) begin m_phase = M_PROGRAM; m_elapsed = 0; end
          else m_elapsed++;
        default: m_phase = M_PROGRAM;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("state", 32'(state_o), 32'(m_phase));
    check("spi_locked", 32'(spi_locked), 32'(m_locked));
    check("usb_pu_dp", 32'(usb_pu_dp), 32'(m_pu));
    check("user_programn", 32'(user_programn), 32'(m_progn));
    check("spi_cs_n_out", 32'(spi_cs_n_out), 32'(spi_cs_n_in | m_locked));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; boot_req = 1'b0; usb_active = 1'b0; spi_cs_n_in = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_boot();
    boot_req = 1'b1; step(); boot_req = 1'b0;
  endtask

  initial begin
    int lat;
    int act_rate;

    // Reset state and auto-boot timeline.
    do_reset();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pu", 32'(usb_pu_dp), 32'd1);
    check("rst_lock", 32'(spi_locked), 32'd0);
    check("rst_progn", 32'(user_programn), 32'd1);
    run(99);
    check("auto_pre_timeout", 32'(state_o), 32'd0);
    step();
    check("auto_drain_at_100", 32'(state_o), 32'd2);
    run(4);
    check("auto_detach_at_104", 32'(state_o), 32'd3);
    step();
    check("auto_lock_at_105", 32'(spi_locked), 32'd1);
    check("auto_pu_off", 32'(usb_pu_dp), 32'd0);
    run(19);
    check("auto_progn_pre", 32'(user_programn), 32'd1);
    step();
    check("auto_progn_at_125", 32'(user_programn), 32'd0);
    run(1000);
    check("auto_progn_held", 32'(user_programn), 32'd0);

    // Session hold: one activity pulse then long idle.
    do_reset();
    run(49);
    usb_active = 1'b1; step(); usb_active = 1'b0;
    run(10000);
    check("session_state", 32'(state_o), 32'd1);
    check("session_pu", 32'(usb_pu_dp), 32'd1);
    check("session_progn", 32'(user_programn), 32'd1);

    // Drain protection with an active transaction and a glitch in the quiet window.
    spi_cs_n_in = 1'b0;
    run(4);
    pulse_boot();
    for (int i = 0; i < 25; i++) begin
      step();
      check("drain_cs_follow", 32'(spi_cs_n_out), 32'd0);
      check("drain_unlocked", 32'(spi_locked), 32'd0);
    end
    spi_cs_n_in = 1'b1;
    run(3);
    spi_cs_n_in = 1'b0; step(); spi_cs_n_in = 1'b1;
    check("glitch_still_drain", 32'(state_o), 32'd2);
    run(3);
    check("quiet_3_drain", 32'(state_o), 32'd2);
    step();
    check("quiet_4_detach", 32'(state_o), 32'd3);
    step();
    check("lock_after_quiet", 32'(spi_locked), 32'd1);
    for (int i = 0; i < 6; i++) begin
      spi_cs_n_in = i[0];
      step();
      check("lock_gating", 32'(spi_cs_n_out), 32'd1);
    end
    spi_cs_n_in = 1'b1;

    // Boot latency with the bus idle.
    do_reset();
    run(10);
    pulse_boot();
    lat = 1;
    while (user_programn !== 1'b0 && lat < 200) begin step(); lat++; end
    check("boot_latency", 32'(lat), 32'(QC + DC + 2));

    // Priority rules.
    do_reset();
    run(3);
    boot_req = 1'b1; usb_active = 1'b1; step(); boot_req = 1'b0; usb_active = 1'b0;
    check("prio_boot_over_act", 32'(state_o), 32'd2);
    do_reset();
    run(99);
    usb_active = 1'b1; step(); usb_active = 1'b0;
    check("prio_act_over_timeout", 32'(state_o), 32'd1);

    // Reset in DETACH and in PROGRAM; timeout restarts from zero.
    do_reset();
    pulse_boot();
    run(QC + 10);
    check("mid_in_detach", 32'(state_o), 32'd3);
    reset = 1'b1; step(); reset = 1'b0;
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_pu", 32'(usb_pu_dp), 32'd1);
    check("mid_rst_lock", 32'(spi_locked), 32'd0);
    run(99);
    check("mid_timeout_pre", 32'(state_o), 32'd0);
    step();
    check("mid_timeout_drain", 32'(state_o), 32'd2);
    run(QC + DC + 5);
    check("mid_in_program", 32'(state_o), 32'd4);
    reset = 1'b1; step(); reset = 1'b0;
    check("prog_rst_state", 32'(state_o), 32'd0);
    check("prog_rst_progn", 32'(user_programn), 32'd1);
    check("prog_rst_pu", 32'(usb_pu_dp), 32'd1);

    // Randomized traffic against the model.
    for (int ep = 0; ep < 20; ep++) begin
      do_reset();
      act_rate = $urandom_range(40, 400);
      for (int c = 0; c < 300; c++) begin
        boot_req    = ($urandom_range(0, 59) == 0);
        usb_active  = ($urandom_range(0, act_rate) == 0);
        if ($urandom_range(0, 5) == 0) spi_cs_n_in = ~spi_cs_n_in;
        reset       = ($urandom_range(0, 399) == 0);
        step();
      end
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
